// File: rtl/ps2_scancode_rx_if.sv
//------------------------------------------------------------------------------
// Module      : ps2_scancode_rx_if
// Description : Key-event bundle from the PS/2 scan-code receiver to the
//               keyboard matrix block.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ps2_scancode_rx_if;
  logic       key_strobe;
  logic       key_pressed;
  logic       key_extended;
  logic [7:0] key_code;
  logic       frame_err;

  modport master (
    output key_strobe,
    output key_pressed,
    output key_extended,
    output key_code,
    output frame_err
  );

  modport slave (
    input key_strobe,
    input key_pressed,
    input key_extended,
    input key_code,
    input frame_err
  );
endinterface

`default_nettype wire

// File: rtl/ps2_scancode_rx.sv
//------------------------------------------------------------------------------
// Module      : ps2_scancode_rx
// Description : PS/2 keyboard receiver. Synchronises and glitch-filters the
//               raw clock/data pair, deserialises 11-bit frames, checks odd
//               parity / stop bit / stalled frames, and folds Set-2 prefix
//               bytes (E0, F0, E1) into single key events.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ps2_scancode_rx #(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 48000
) (
  input  wire logic           clk_sys,
  input  wire logic           reset_n,
  input  wire logic           ps2_clk,
  input  wire logic           ps2_data,
  ps2_scancode_rx_if.master   key_if
);

  localparam int c_FCNT_W = $clog2(FILTER_LEN + 1);
  localparam int c_TCNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Synchroniser and filter state
  logic                r_clk_s1, r_clk_s2;
  logic                r_dat_s1, r_dat_s2;
  logic                r_clk_filt;
  logic [c_FCNT_W-1:0] r_filt_cnt;
  logic                w_filt_flip;
  logic                w_fall_evt;

  // Frame and byte-handler state
  state_t              r_state,    w_state_nxt;
  logic [2:0]          r_bit_cnt,  w_bit_cnt_nxt;
  logic [7:0]          r_shift,    w_shift_nxt;
  logic                r_par_bit,  w_par_bit_nxt;
  logic [c_TCNT_W-1:0] r_to_cnt,   w_to_cnt_nxt;
  logic                r_ext,      w_ext_nxt;
  logic                r_brk,      w_brk_nxt;
  logic [2:0]          r_skip,     w_skip_nxt;
  logic                r_strobe,   w_strobe_nxt;
  logic                r_pressed,  w_pressed_nxt;
  logic                r_extended, w_extended_nxt;
  logic [7:0]          r_code,     w_code_nxt;
  logic                r_err,      w_err_nxt;
  logic                w_timeout;
  logic                w_frame_ok;

  // Two-flop synchronisers; idle PS/2 lines are high, so reset to 1
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // The filtered clock flips on the FILTER_LEN-th consecutive differing sample
  assign w_filt_flip = (r_clk_s2 != r_clk_filt) &&
                       (r_filt_cnt == c_FCNT_W'(FILTER_LEN - 1));
  assign w_fall_evt  = w_filt_flip && r_clk_filt;

  // Glitch filter: count disagreeing samples, clear on any agreeing one
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_filt <= 1'b1;
      r_filt_cnt <= '0;
    end else if (r_clk_s2 == r_clk_filt) begin
      r_filt_cnt <= '0;
    end else if (w_filt_flip) begin
      r_clk_filt <= ~r_clk_filt;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + c_FCNT_W'(1);
    end
  end

  assign w_timeout  = (r_to_cnt == c_TCNT_W'(TIMEOUT));
  // Odd parity over data + parity bit, and a high stop bit
  assign w_frame_ok = r_dat_s2 && (^{r_shift, r_par_bit});

  // Next-state: frame FSM, stall timeout and prefix-collapsing byte handler
  always_comb begin
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_par_bit_nxt  = r_par_bit;
    w_ext_nxt      = r_ext;
    w_brk_nxt      = r_brk;
    w_skip_nxt     = r_skip;
    w_pressed_nxt  = r_pressed;
    w_extended_nxt = r_extended;
    w_code_nxt     = r_code;
    w_strobe_nxt   = 1'b0;
    w_err_nxt      = 1'b0;
    w_to_cnt_nxt   = (r_state == ST_IDLE || w_fall_evt) ? '0
                                                        : r_to_cnt + c_TCNT_W'(1);

    case (r_state)
      ST_IDLE: begin
        if (w_fall_evt && !r_dat_s2) begin
          w_state_nxt   = ST_DATA;
          w_bit_cnt_nxt = 3'd0;
        end
      end
      ST_DATA: begin
        if (w_fall_evt) begin
          w_shift_nxt = {r_dat_s2, r_shift[7:1]};
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = ST_PARITY;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (w_fall_evt) begin
          w_par_bit_nxt = r_dat_s2;
          w_state_nxt   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_fall_evt) begin
          w_state_nxt = ST_IDLE;
          if (!w_frame_ok) begin
            w_err_nxt  = 1'b1;
            w_ext_nxt  = 1'b0;
            w_brk_nxt  = 1'b0;
            w_skip_nxt = 3'd0;
          end else if (r_skip != 3'd0) begin
            // Remainder of the Pause sequence is swallowed
            w_skip_nxt = r_skip - 3'd1;
          end else begin
            case (r_shift)
              8'hE1: w_skip_nxt = 3'd7;
              8'hE0: w_ext_nxt  = 1'b1;
              8'hF0: w_brk_nxt  = 1'b1;
              8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: begin
                w_ext_nxt = 1'b0;
                w_brk_nxt = 1'b0;
              end
              default: begin
                w_strobe_nxt   = 1'b1;
                w_code_nxt     = r_shift;
                w_pressed_nxt  = ~r_brk;
                w_extended_nxt = r_ext;
                w_ext_nxt      = 1'b0;
                w_brk_nxt      = 1'b0;
              end
            endcase
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Stalled frame: a clock fall in the same cycle takes precedence
    if (r_state != ST_IDLE && w_timeout && !w_fall_evt) begin
      w_state_nxt  = ST_IDLE;
      w_err_nxt    = 1'b1;
      w_ext_nxt    = 1'b0;
      w_brk_nxt    = 1'b0;
      w_skip_nxt   = 3'd0;
      w_to_cnt_nxt = '0;
    end
  end

  // State register for the frame FSM, byte handler and registered outputs
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
      r_par_bit  <= 1'b0;
      r_to_cnt   <= '0;
      r_ext      <= 1'b0;
      r_brk      <= 1'b0;
      r_skip     <= 3'd0;
      r_strobe   <= 1'b0;
      r_pressed  <= 1'b0;
      r_extended <= 1'b0;
      r_code     <= 8'h00;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_par_bit  <= w_par_bit_nxt;
      r_to_cnt   <= w_to_cnt_nxt;
      r_ext      <= w_ext_nxt;
      r_brk      <= w_brk_nxt;
      r_skip     <= w_skip_nxt;
      r_strobe   <= w_strobe_nxt;
      r_pressed  <= w_pressed_nxt;
      r_extended <= w_extended_nxt;
      r_code     <= w_code_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign key_if.key_strobe   = r_strobe;
  assign key_if.key_pressed  = r_pressed;
  assign key_if.key_extended = r_extended;
  assign key_if.key_code     = r_code;
  assign key_if.frame_err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_scancode_rx.sv
//------------------------------------------------------------------------------
// Module      : tb_ps2_scancode_rx
// Description : Self-checking bench for ps2_scancode_rx: directed vector
//               table, multi-frame corner sequences and random frames checked
//               against a byte-level reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ps2_scancode_rx;

  localparam int FILT = 4;
  localparam int TMO  = 600;
  localparam int H    = 20;   // PS/2 half bit period in clk_sys cycles

  logic clk_sys  = 1'b0;
  logic reset_n  = 1'b0;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;

  ps2_scancode_rx_if key_if ();

  ps2_scancode_rx #(.FILTER_LEN(FILT), .TIMEOUT(TMO)) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_if   (key_if)
  );

  always #5 clk_sys = ~clk_sys;

  int n_vec = 0;
  int n_bad = 0;

  // Cycle counter and output monitor
  int         cyc = 0;
  int         fall_cyc = 0;
  int         st_cnt = 0, err_cnt = 0, viol = 0, last_lat = 0;
  logic [7:0] last_code = 8'h00;
  logic       last_p = 1'b0, last_e = 1'b0;
  logic       prev_st = 1'b0, prev_err = 1'b0, prev_rst = 1'b0;
  logic       prev_p = 1'b0, prev_e = 1'b0;
  logic [7:0] prev_code = 8'h00;

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (key_if.key_strobe) begin
      st_cnt    <= st_cnt + 1;
      last_code <= key_if.key_code;
      last_p    <= key_if.key_pressed;
      last_e    <= key_if.key_extended;
      last_lat  <= cyc - fall_cyc;
    end
    if (key_if.frame_err) err_cnt <= err_cnt + 1;
    if ((key_if.key_strobe && key_if.frame_err) ||
        (key_if.key_strobe && prev_st) || (key_if.frame_err && prev_err) ||
        (reset_n && prev_rst && !key_if.key_strobe &&
         (key_if.key_code != prev_code || key_if.key_pressed != prev_p ||
          key_if.key_extended != prev_e)))
      viol <= viol + 1;
    prev_st   <= key_if.key_strobe;
    prev_err  <= key_if.frame_err;
    prev_rst  <= reset_n;
    prev_code <= key_if.key_code;
    prev_p    <= key_if.key_pressed;
    prev_e    <= key_if.key_extended;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Drive nbits of a frame LSB first; optional short clock glitch in the high
  // phase before bit index glitch_at
  task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_at);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (i == glitch_at) begin
        idle(H / 2);
        ps2_clk = 1'b0;
        idle(2);
        ps2_clk = 1'b1;
        idle(H - H / 2 - 2);
      end else begin
        idle(H);
      end
      ps2_clk  = 1'b0;
      fall_cyc = cyc;
      idle(H);
      ps2_clk  = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                           input int glitch_at);
    logic par;
    par = (~^b) ^ bad_par;
    send_bits({~bad_stop, par, b, 1'b0}, 11, glitch_at);
    ps2_data = 1'b1;
    idle(H);
  endtask

  typedef struct {
    logic [3:0][7:0] b;
    int              n;
    int              exp_st;
    logic [7:0]      code;
    logic            p;
    logic            e;
  } vec_t;

  vec_t tbl[10];

  int s0, e0;
  int m_skip;
  logic m_ext, m_brk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{b: {8'h00, 8'h00, 8'h00, 8'h1C}, n: 1, exp_st: 1, code: 8'h1C, p: 1'b1, e: 1'b0};
    tbl[1] = '{b: {8'h00, 8'h75, 8'hF0, 8'hE0}, n: 3, exp_st: 1, code: 8'h75, p: 1'b0, e: 1'b1};
    tbl[2] = '{b: {8'h00, 8'h00, 8'h00, 8'h1C}, n: 1, exp_st: 1, code: 8'h1C, p: 1'b1, e: 1'b0};
    tbl[3] = '{b: {8'h00, 8'h00, 8'h1C, 8'hF0}, n: 2, exp_st: 1, code: 8'h1C, p: 1'b0, e: 1'b0};
    tbl[4] = '{b: {8'h00, 8'h00, 8'h1C, 8'hE0}, n: 2, exp_st: 1, code: 8'h1C, p: 1'b1, e: 1'b1};
    tbl[5] = '{b: {8'h00, 8'h1C, 8'hFA, 8'hE0}, n: 3, exp_st: 1, code: 8'h1C, p: 1'b1, e: 1'b0};
    tbl[6] = '{b: {8'h00, 8'h00, 8'h00, 8'hAA}, n: 1, exp_st: 0, code: 8'h00, p: 1'b0, e: 1'b0};
    tbl[7] = '{b: {8'h00, 8'h29, 8'h00, 8'hF0}, n: 3, exp_st: 1, code: 8'h29, p: 1'b1, e: 1'b0};
    tbl[8] = '{b: {8'h00, 8'hEE, 8'hF0, 8'hE0}, n: 3, exp_st: 0, code: 8'h00, p: 1'b0, e: 1'b0};
    tbl[9] = '{b: {8'h00, 8'h00, 8'h00, 8'h5A}, n: 1, exp_st: 1, code: 8'h5A, p: 1'b1, e: 1'b0};

    // Reset state
    idle(5);
    check("rst_strobe",  key_if.key_strobe,   0);
    check("rst_pressed", key_if.key_pressed,  0);
    check("rst_ext",     key_if.key_extended, 0);
    check("rst_code",    key_if.key_code,     0);
    check("rst_err",     key_if.frame_err,    0);
    reset_n = 1'b1;
    idle(10);

    // Directed vector table
    for (int v = 0; v < 10; v++) begin
      s0 = st_cnt; e0 = err_cnt;
      for (int j = 0; j < tbl[v].n; j++) send_byte(tbl[v].b[j], 1'b0, 1'b0, -1);
      idle(10);
      check($sformatf("tbl%0d_strobes", v), st_cnt - s0, tbl[v].exp_st);
      check($sformatf("tbl%0d_errs", v), err_cnt - e0, 0);
      if (tbl[v].exp_st == 1) begin
        check($sformatf("tbl%0d_code", v), last_code, tbl[v].code);
        check($sformatf("tbl%0d_pressed", v), last_p, tbl[v].p);
        check($sformatf("tbl%0d_ext", v), last_e, tbl[v].e);
        check($sformatf("tbl%0d_latency_ok", v), (last_lat >= 1 && last_lat <= FILT + 4), 1);
      end
    end

    // Parity error, then F0 1C
    s0 = st_cnt; e0 = err_cnt;
    send_byte(8'h1C, 1'b1, 1'b0, -1);
    idle(10);
    check("par_err_cnt", err_cnt - e0, 1);
    check("par_err_strobes", st_cnt - s0, 0);
    s0 = st_cnt;
    send_byte(8'hF0, 1'b0, 1'b0, -1);
    send_byte(8'h1C, 1'b0, 1'b0, -1);
    idle(10);
    check("after_par_strobes", st_cnt - s0, 1);
    check("after_par_pressed", last_p, 0);
    check("after_par_code", last_code, 8'h1C);

    // Stop-bit error clears a pending F0 prefix
    s0 = st_cnt; e0 = err_cnt;
    send_byte(8'hF0, 1'b0, 1'b0, -1);
    send_byte(8'h1C, 1'b0, 1'b1, -1);
    send_byte(8'h1C, 1'b0, 1'b0, -1);
    idle(10);
    check("stop_err_cnt", err_cnt - e0, 1);
    check("stop_err_strobes", st_cnt - s0, 1);
    check("stop_err_pressed", last_p, 1);

    // Stalled frame: start bit plus 4 data bits of 29, then idle lines
    s0 = st_cnt; e0 = err_cnt;
    send_bits({1'b1, 1'b1, 8'h29, 1'b0}, 5, -1);
    ps2_data = 1'b1;
    idle(TMO + 100);
    check("timeout_err", err_cnt - e0, 1);
    check("timeout_strobes", st_cnt - s0, 0);
    send_byte(8'h29, 1'b0, 1'b0, -1);
    idle(10);
    check("after_to_strobes", st_cnt - s0, 1);
    check("after_to_code", last_code, 8'h29);

    // Reset pulsed mid-frame
    s0 = st_cnt; e0 = err_cnt;
    send_bits({1'b1, 1'b1, 8'h29, 1'b0}, 5, -1);
    ps2_data = 1'b1;
    reset_n  = 1'b0;
    idle(3);
    reset_n  = 1'b1;
    idle(2);
    check("midrst_code", key_if.key_code, 0);
    idle(TMO + 100);
    check("midrst_err", err_cnt - e0, 0);
    check("midrst_strobes", st_cnt - s0, 0);
    send_byte(8'h29, 1'b0, 1'b0, -1);
    idle(10);
    check("after_rst_strobes", st_cnt - s0, 1);
    check("after_rst_code", last_code, 8'h29);

    // Glitch between data bits 3 and 4 (before frame bit index 5)
    s0 = st_cnt; e0 = err_cnt;
    send_byte(8'h45, 1'b0, 1'b0, 5);
    idle(10);
    check("glitch_strobes", st_cnt - s0, 1);
    check("glitch_code", last_code, 8'h45);
    check("glitch_err", err_cnt - e0, 0);

    // Pause sequence, then 29
    s0 = st_cnt;
    foreach (tbl[0].b[k]) begin end
    begin
      logic [7:0] pause_seq [9];
      pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h29};
      for (int j = 0; j < 9; j++) send_byte(pause_seq[j], 1'b0, 1'b0, -1);
    end
    idle(10);
    check("pause_strobes", st_cnt - s0, 1);
    check("pause_code", last_code, 8'h29);
    check("pause_pressed", last_p, 1);

    // Random frames against a byte-level reference model
    m_skip = 0; m_ext = 1'b0; m_brk = 1'b0;
    for (int it = 0; it < 30; it++) begin
      logic [7:0] b;
      logic [7:0] drops [7];
      bit         bad;
      int         exp_st, exp_err, r;
      logic [7:0] exp_code;
      logic       exp_p, exp_e;
      drops = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
      r = $urandom_range(0, 9);
      if (r == 0)                                      b = 8'hE0;
      else if (r == 1)                                 b = 8'hF0;
      else if (r == 2)                                 b = drops[$urandom_range(0, 6)];
      else if (r == 3 && $urandom_range(0, 2) == 0)    b = 8'hE1;
      else                                             b = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 7) == 0);
      exp_st = 0; exp_err = 0; exp_code = 8'h00; exp_p = 1'b0; exp_e = 1'b0;
      if (bad) begin
        exp_err = 1; m_skip = 0; m_ext = 1'b0; m_brk = 1'b0;
      end else if (m_skip > 0) begin
        m_skip = m_skip - 1;
      end else if (b == 8'hE1) begin
        m_skip = 7;
      end else if (b == 8'hE0) begin
        m_ext = 1'b1;
      end else if (b == 8'hF0) begin
        m_brk = 1'b1;
      end else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF}) begin
        m_ext = 1'b0; m_brk = 1'b0;
      end else begin
        exp_st = 1; exp_code = b; exp_p = ~m_brk; exp_e = m_ext;
        m_ext = 1'b0; m_brk = 1'b0;
      end
      s0 = st_cnt; e0 = err_cnt;
      send_byte(b, bad, 1'b0, -1);
      idle(10);
      check($sformatf("rnd%0d_strobes(b=%h)", it, b), st_cnt - s0, exp_st);
      check($sformatf("rnd%0d_errs", it), err_cnt - e0, exp_err);
      if (exp_st == 1) begin
        check($sformatf("rnd%0d_code", it), last_code, exp_code);
        check($sformatf("rnd%0d_pressed", it), last_p, exp_p);
        check($sformatf("rnd%0d_ext", it), last_e, exp_e);
      end
    end

    idle(5);
    check("pulse_rules_violations", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
